// File: rtl/test_alu.sv
// Registered ALU wrapper for bring-up of the execute-stage operations.
// One cycle of latency: out holds f(op, a, b, Shamt) sampled on the previous rising edge.
module test_alu #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [15:0]      in,
    input  logic [SHW-1:0]   Shamt,
    output logic [WIDTH-1:0] out
);

    typedef enum logic [3:0] {
        OpAnd  = 4'h0,
        OpOr   = 4'h1,
        OpAdd  = 4'h2,
        OpSub  = 4'h3,
        OpXor  = 4'h4,
        OpNor  = 4'h5,
        OpSlt  = 4'h6,
        OpSltu = 4'h7,
        OpSll  = 4'h8,
        OpSrl  = 4'h9,
        OpSra  = 4'hA,
        OpSllv = 4'hB,
        OpSrlv = 4'hC,
        OpSrav = 4'hD,
        OpLui  = 4'hE,
        OpRor  = 4'hF
    } op_e;

    op_e op;
    assign op = op_e'(in[3:0]);

    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    // Shared adder: ADD uses b, SUB/SLT/SLTU use a + ~b + 1.
    logic             sub_en;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    logic             lt_signed;
    logic             lt_unsigned;

    always_comb begin
        sub_en      = (op != OpAdd);
        b_eff       = sub_en ? ~b : b;
        sum_full    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_en};
        sum         = sum_full[WIDTH-1:0];
        carry       = sum_full[WIDTH];
        ovf         = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ sum[WIDTH-1]);
        lt_signed   = sum[WIDTH-1] ^ ovf;
        // No carry out of a + ~b + 1 means a borrow, i.e. a < b unsigned.
        lt_unsigned = ~carry;
    end

    // One funnel shifter serves every shift: {hi, lo} >> amt, keep the low word.
    // Left shifts run through it on bit-reversed data.
    logic                 shift_left;
    logic                 shift_var;
    logic [SHW-1:0]       shift_amt;
    logic [WIDTH-1:0]     funnel_hi;
    logic [WIDTH-1:0]     funnel_lo;
    logic [2*WIDTH-1:0]   funnel;
    logic [WIDTH-1:0]     shift_res;

    always_comb begin
        shift_left = (op == OpSll) || (op == OpSllv);
        shift_var  = (op == OpSllv) || (op == OpSrlv) || (op == OpSrav);
        shift_amt  = shift_var ? a[SHW-1:0] : Shamt;

        funnel_lo = shift_left ? bit_reverse(b) : b;
        if ((op == OpSra) || (op == OpSrav)) begin
            funnel_hi = {WIDTH{b[WIDTH-1]}};
        end else if (op == OpRor) begin
            funnel_hi = b;
        end else begin
            funnel_hi = '0;
        end

        funnel = {funnel_hi, funnel_lo};
        for (int k = 0; k < int'(SHW); k++) begin
            if (shift_amt[k]) begin
                funnel = funnel >> (2 ** k);
            end
        end

        shift_res = shift_left ? bit_reverse(funnel[WIDTH-1:0]) : funnel[WIDTH-1:0];
    end

    logic [WIDTH-1:0] result;

    always_comb begin
        result = '0;
        unique case (op)
            OpAnd:  result = a & b;
            OpOr:   result = a | b;
            OpAdd:  result = sum;
            OpSub:  result = sum;
            OpXor:  result = a ^ b;
            OpNor:  result = ~(a | b);
            OpSlt:  result = {{(WIDTH-1){1'b0}}, lt_signed};
            OpSltu: result = {{(WIDTH-1){1'b0}}, lt_unsigned};
            OpSll:  result = shift_res;
            OpSrl:  result = shift_res;
            OpSra:  result = shift_res;
            OpSllv: result = shift_res;
            OpSrlv: result = shift_res;
            OpSrav: result = shift_res;
            OpLui:  result = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OpRor:  result = shift_res;
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= result;
        end
    end

endmodule

// File: tb/tb_test_alu.sv
// Directed bench for test_alu: each vector is driven on the falling edge and the
// registered result is checked just after the following rising edge.
module tb_test_alu;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] in;
    logic [4:0]  Shamt;
    logic [31:0] out;

    int checks;
    int errors;

    test_alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .in    (in),
        .Shamt (Shamt),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one vector, clock it in, then compare the registered result.
    task automatic apply(input string tag, input logic r, input logic [15:0] ctl,
                         input logic [31:0] va, input logic [31:0] vb,
                         input logic [4:0] sh, input logic [31:0] exp);
        @(negedge clk);
        rst   = r;
        in    = ctl;
        a     = va;
        b     = vb;
        Shamt = sh;
        @(posedge clk);
        #1;
        check_val(tag, out, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        in     = 16'h0002;
        a      = 32'h1234;
        b      = 32'h1111;
        Shamt  = 5'd3;

        // Reset overrides a live ADD.
        apply("reset",        1'b1, 16'h0002, 32'h1234,     32'h1111,     5'd3,  32'h0000_0000);

        // Rotate, with the ignored control bits all set.
        apply("ror_ones",     1'b0, 16'hFFFF, 32'h0000_00FF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF);
        apply("ror_f",        1'b0, 16'hFFFF, 32'h0000_00FF, 32'h0000_000F, 5'd4,  32'hF000_0000);
        apply("ror_8",        1'b0, 16'h000F, 32'h0,        32'h1234_5678, 5'd8,  32'h7812_3456);
        apply("ror_0",        1'b0, 16'h000F, 32'h0,        32'h1234_5678, 5'd0,  32'h1234_5678);

        // Stable between edges: still the ROR-0 result on the next falling edge.
        @(negedge clk);
        check_val("hold", out, 32'h1234_5678);

        // Arithmetic
        apply("add_wrap",     1'b0, 16'h0002, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000);
        apply("sub_0m1",      1'b0, 16'h0003, 32'h0000_0000, 32'h0000_0001, 5'd0,  32'hFFFF_FFFF);
        apply("sub_5m7",      1'b0, 16'h0003, 32'h0000_0005, 32'h0000_0007, 5'd0,  32'hFFFF_FFFE);

        // Compares
        apply("slt_m1_1",     1'b0, 16'h0006, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001);
        apply("sltu_m1_1",    1'b0, 16'h0007, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000);
        apply("slt_5_m1",     1'b0, 16'h0006, 32'h0000_0005, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000);
        apply("sltu_5_m1",    1'b0, 16'h0007, 32'h0000_0005, 32'hFFFF_FFFF, 5'd0,  32'h0000_0001);
        apply("slt_ovf",      1'b0, 16'h0006, 32'h8000_0000, 32'h7FFF_FFFF, 5'd0,  32'h0000_0001);

        // Shifts
        apply("srl_4",        1'b0, 16'h0009, 32'h0,        32'h8000_0000, 5'd4,  32'h0800_0000);
        apply("sra_4",        1'b0, 16'h000A, 32'h0,        32'h8000_0000, 5'd4,  32'hF800_0000);
        apply("sra_31",       1'b0, 16'h000A, 32'h0,        32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
        apply("srav_1",       1'b0, 16'h000D, 32'h0000_0021, 32'h8000_0000, 5'd4,  32'hC000_0000);
        apply("sll_31",       1'b0, 16'h0008, 32'h0,        32'h0000_0001, 5'd31, 32'h8000_0000);
        apply("sll_0",        1'b0, 16'h0008, 32'h0,        32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
        apply("sllv_hi_ign",  1'b0, 16'h000B, 32'hFFFF_FFE3, 32'h0000_0001, 5'd9,  32'h0000_0008);
        apply("srlv_4",       1'b0, 16'h000C, 32'h0000_0004, 32'hF000_0000, 5'd0,  32'h0F00_0000);

        // Logic and LUI
        apply("and",          1'b0, 16'h0000, 32'h0000_00FF, 32'h0000_F0F0, 5'd0,  32'h0000_00F0);
        apply("or",           1'b0, 16'h0001, 32'h0000_00FF, 32'h0000_F0F0, 5'd0,  32'h0000_F0FF);
        apply("xor",          1'b0, 16'h0004, 32'h0000_00FF, 32'h0000_F0F0, 5'd0,  32'h0000_F00F);
        apply("nor",          1'b0, 16'h0005, 32'h0000_00FF, 32'h0000_F0F0, 5'd0,  32'hFFFF_0F00);
        apply("lui",          1'b0, 16'h000E, 32'h0000_00FF, 32'h0000_F0F0, 5'd0,  32'hF0F0_0000);
        apply("and_ign_bits", 1'b0, 16'hABC0, 32'h0000_00FF, 32'h0000_F0F0, 5'd0,  32'h0000_00F0);

        // Reset mid-stream, then release and resume.
        apply("reset_again",  1'b1, 16'h0001, 32'h0000_00FF, 32'h0000_F0F0, 5'd0,  32'h0000_0000);
        apply("after_reset",  1'b0, 16'h0001, 32'h0000_00FF, 32'h0000_F0F0, 5'd0,  32'h0000_F0FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
